// File: rtl/icache_pm.sv
// rtl/icache_pm.sv - direct-mapped 48-bit-fetch instruction cache with Wishbone line fill
//
// Purpose: returns the halfword at adr_i plus the following 32 bits. Both lines touched
// by the 48-bit window are filled in turn on a miss. A bus error aborts the fill and
// leaves the line invalid.
// Optional feature: define ICACHE_INVALIDATE_EN to add the inval_i flush port.
// Ports:
//   clk_i, rst_i                  clock, synchronous active-high reset
//   adr_i, stb_i                  fetch address (halfword aligned) and lookup request
//   hit_o, inst_o, data_o         hit flag, halfword at adr_i, {hw @ adr_i+2, hw @ adr_i+4}
//   err_o                         one-cycle pulse when a fill ends on wb_err_i
//   wb_adr_o, wb_dat_i, wb_sel_o,
//   wb_cyc_o, wb_stb_o,
//   wb_ack_i, wb_err_i            16-bit Wishbone read master
//   inval_i                       flush all lines (ICACHE_INVALIDATE_EN only)
module icache_pm #(
    parameter int SETS_LOG2 = 8,
    parameter int LINE_LOG2 = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] adr_i,
    input  logic        stb_i,
    output logic        hit_o,
    output logic [15:0] inst_o,
    output logic [31:0] data_o,
    output logic        err_o,
    output logic [31:0] wb_adr_o,
    input  logic [15:0] wb_dat_i,
    output logic [1:0]  wb_sel_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    input  logic        wb_ack_i,
`ifdef ICACHE_INVALIDATE_EN
    input  logic        wb_err_i,
    input  logic        inval_i
`else
    input  logic        wb_err_i
`endif
);
    localparam int TAG_W  = 31 - SETS_LOG2 - LINE_LOG2;
    localparam int TAG_LO = 32 - TAG_W;
    localparam int IDX_LO = LINE_LOG2 + 1;
    localparam int NSETS  = 1 << SETS_LOG2;
    localparam int NWORDS = 1 << (SETS_LOG2 + LINE_LOG2);

    typedef enum logic {IDLE, FILL} state_t;

    state_t                 state_q, state_d;
    logic [LINE_LOG2-1:0]   count_q, count_d;
    logic [31:0]            adr_q, adr_d;
    logic                   stb_q, stb_d;
    logic                   err_q, err_d;
    logic                   pend_q, pend_d;
    logic [NSETS-1:0]       valid_q, valid_d;
    logic [TAG_W-1:0]       tgt_tag_q, tgt_tag_d;
    logic [SETS_LOG2-1:0]   tgt_idx_q, tgt_idx_d;

    logic [TAG_W-1:0]       tag_q [NSETS];
    logic [15:0]            mem_q [NWORDS];
    logic                   data_we, tag_we;

    // Line B is the line of adr_i+4; its tag/index come from the incremented address,
    // so an index wrap naturally yields tagA+1 and index 0.
    logic [31:0]            adr_h1, adr_b;
    logic [TAG_W-1:0]       tag_a, tag_b, miss_tag;
    logic [SETS_LOG2-1:0]   idx_a, idx_b, miss_idx;
    logic                   hit_a, hit_b, inval_now;
    logic                   unused_bits;

    assign adr_h1 = adr_i + 32'd2;
    assign adr_b  = adr_i + 32'd4;
    assign tag_a  = adr_i[31:TAG_LO];
    assign tag_b  = adr_b[31:TAG_LO];
    assign idx_a  = adr_i[TAG_LO-1:IDX_LO];
    assign idx_b  = adr_b[TAG_LO-1:IDX_LO];
    assign hit_a  = valid_q[idx_a] && (tag_q[idx_a] == tag_a);
    assign hit_b  = valid_q[idx_b] && (tag_q[idx_b] == tag_b);
    assign unused_bits = ^{adr_i[0], adr_h1[0], adr_b[0]};

    assign hit_o    = !rst_i && (state_q == IDLE) && hit_a && hit_b;
    // {index, offset} of a halfword address is its slot in the flat data array.
    assign inst_o   = mem_q[adr_i[TAG_LO-1:1]];
    assign data_o   = {mem_q[adr_h1[TAG_LO-1:1]], mem_q[adr_b[TAG_LO-1:1]]};
    assign err_o    = err_q;
    assign wb_adr_o = adr_q;
    assign wb_sel_o = 2'b11;
    assign wb_cyc_o = stb_q;
    assign wb_stb_o = stb_q;

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        adr_d     = adr_q;
        stb_d     = stb_q;
        err_d     = 1'b0;
        pend_d    = pend_q;
        valid_d   = valid_q;
        tgt_tag_d = tgt_tag_q;
        tgt_idx_d = tgt_idx_q;
        data_we   = 1'b0;
        tag_we    = 1'b0;
        inval_now = 1'b0;
`ifdef ICACHE_INVALIDATE_EN
        inval_now = inval_i;
`endif
        // Line A is filled first; line B only once A is present.
        miss_tag = hit_a ? tag_b : tag_a;
        miss_idx = hit_a ? idx_b : idx_a;
        case (state_q)
            IDLE: begin
                if (inval_now) begin
                    valid_d = '0;
                end else if (stb_i && !(hit_a && hit_b)) begin
                    tgt_tag_d          = miss_tag;
                    tgt_idx_d          = miss_idx;
                    valid_d[miss_idx]  = 1'b0;
                    adr_d              = {miss_tag, miss_idx, {(LINE_LOG2 + 1){1'b0}}};
                    count_d            = '0;
                    stb_d              = 1'b1;
                    state_d            = FILL;
                end
            end
            FILL: begin
                pend_d = pend_q | inval_now;
                if (wb_err_i) begin
                    stb_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = IDLE;
                    if (pend_d) begin
                        valid_d = '0;
                        pend_d  = 1'b0;
                    end
                end else if (wb_ack_i) begin
                    data_we = 1'b1;
                    adr_d   = adr_q + 32'd2;
                    count_d = count_q + 1'b1;
                    if (count_q == {LINE_LOG2{1'b1}}) begin
                        stb_d   = 1'b0;
                        state_d = IDLE;
                        // A flush requested mid-fill wins over validating the new line.
                        if (pend_d) begin
                            valid_d = '0;
                            pend_d  = 1'b0;
                        end else begin
                            tag_we             = 1'b1;
                            valid_d[tgt_idx_q] = 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            count_q   <= '0;
            adr_q     <= '0;
            stb_q     <= 1'b0;
            err_q     <= 1'b0;
            pend_q    <= 1'b0;
            valid_q   <= '0;
            tgt_tag_q <= '0;
            tgt_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            adr_q     <= adr_d;
            stb_q     <= stb_d;
            err_q     <= err_d;
            pend_q    <= pend_d;
            valid_q   <= valid_d;
            tgt_tag_q <= tgt_tag_d;
            tgt_idx_q <= tgt_idx_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && data_we) begin
            mem_q[{tgt_idx_q, count_q}] <= wb_dat_i;
        end
        if (!rst_i && tag_we) begin
            tag_q[tgt_idx_q] <= tgt_tag_q;
        end
    end
endmodule

// File: tb/tb_icache_pm.sv
// tb/tb_icache_pm.sv - directed self-checking bench for icache_pm
module tb_icache_pm;
    logic        clk = 1'b0;
    logic        rst_main = 1'b1;
    logic        slave_rst = 1'b0;
    logic        rst_i;
    logic [31:0] adr_i = 32'd0;
    logic        stb_i = 1'b0;
    logic        hit_o, err_o, wb_cyc_o, wb_stb_o;
    logic [15:0] inst_o;
    logic [31:0] data_o, wb_adr_o;
    logic [1:0]  wb_sel_o;
    logic [15:0] wb_dat_i = 16'd0;
    logic        wb_ack_i = 1'b0;
    logic        wb_err_i = 1'b0;
`ifdef ICACHE_INVALIDATE_EN
    logic        inval_i = 1'b0;
`endif

    assign rst_i = rst_main | slave_rst;

    icache_pm dut (
        .clk_i(clk), .rst_i(rst_i), .adr_i(adr_i), .stb_i(stb_i),
        .hit_o(hit_o), .inst_o(inst_o), .data_o(data_o), .err_o(err_o),
        .wb_adr_o(wb_adr_o), .wb_dat_i(wb_dat_i), .wb_sel_o(wb_sel_o),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_ack_i(wb_ack_i),
`ifdef ICACHE_INVALIDATE_EN
        .wb_err_i(wb_err_i), .inval_i(inval_i)
`else
        .wb_err_i(wb_err_i)
`endif
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    int lat = 0;
    int wcnt = 0;
    int beat = 0;
    int err_beat = -1;
    int rst_beat = -1;

    logic [31:0] ack_log [256];
    int ack_n = 0;
    int err_pulses = 0;
    int cyc_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Slave: returns halfword = address[15:0], with lat idle cycles before each beat.
    always @(negedge clk) begin
        slave_rst = 1'b0;
        if (!wb_stb_o) begin
            wb_ack_i = 1'b0; wb_err_i = 1'b0; wcnt = 0;
        end else if (wcnt >= lat) begin
            wcnt = 0;
            beat++;
            if (beat == err_beat) begin
                wb_err_i = 1'b1; wb_ack_i = 1'b0;
            end else begin
                wb_err_i = 1'b0; wb_ack_i = 1'b1;
                wb_dat_i = wb_adr_o[15:0];
                if (beat == rst_beat) slave_rst = 1'b1;
            end
        end else begin
            wb_ack_i = 1'b0; wb_err_i = 1'b0; wcnt++;
        end
    end

    always @(posedge clk) begin
        if (!rst_i && wb_stb_o && wb_ack_i && !wb_err_i && ack_n < 256) begin
            ack_log[ack_n] = wb_adr_o;
            ack_n++;
        end
        if (wb_cyc_o !== wb_stb_o) cyc_bad++;
    end

    always @(negedge clk) if (err_o) err_pulses++;

    task automatic lookup(input logic [31:0] a, input int max, output int cyc);
        @(negedge clk);
        adr_i = a; stb_i = 1'b1;
        #1;
        cyc = 0;
        while (!hit_o && cyc < max) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    int cyc, base, e0, w;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_hit", hit_o, 1'b0);
        check("rst_stb", wb_stb_o, 1'b0);
        check("rst_cyc", wb_cyc_o, 1'b0);
        check("rst_adr", wb_adr_o, 32'h0);
        check("rst_err", err_o, 1'b0);
        check("sel", wb_sel_o, 2'b11);
        @(negedge clk);
        rst_main = 1'b0;
        #1;
        check("idle_no_hit", hit_o, 1'b0);

        // Cold miss: one line, zero-wait slave.
        base = ack_n;
        lookup(32'h1000, 100, cyc);
        check("cold_cycles", cyc, 17);
        check("cold_acks", ack_n - base, 16);
        for (int i = 0; i < 16; i++)
            check($sformatf("cold_adr%0d", i), ack_log[base + i], 32'h1000 + 2 * i);
        check("cold_inst", inst_o, 16'h1000);
        check("cold_data", data_o, 32'h1002_1004);

        // Straddle: both lines missing, filled back to back.
        base = ack_n;
        lookup(32'h103C, 200, cyc);
        check("strad_cycles", cyc, 34);
        check("strad_acks", ack_n - base, 32);
        check("strad_a0", ack_log[base], 32'h1020);
        check("strad_a15", ack_log[base + 15], 32'h103E);
        check("strad_b0", ack_log[base + 16], 32'h1040);
        check("strad_b15", ack_log[base + 31], 32'h105E);
        check("strad_inst", inst_o, 16'h103C);
        check("strad_data", data_o, 32'h103E_1040);
        lookup(32'h1000, 5, cyc);
        check("rehit_cycles", cyc, 0);
        check("rehit_data", data_o, 32'h1002_1004);

        // Index wrap: line B sits at tag+1, index 0.
        base = ack_n;
        lookup(32'h1FFC, 200, cyc);
        check("wrap_cycles", cyc, 34);
        check("wrap_a0", ack_log[base], 32'h1FE0);
        check("wrap_b0", ack_log[base + 16], 32'h2000);
        check("wrap_inst", inst_o, 16'h1FFC);
        check("wrap_data", data_o, 32'h1FFE_2000);

        // Wait states with an error on the 5th beat; the retry refills the whole line.
        lat = 3;
        err_beat = beat + 5;
        base = ack_n;
        e0 = err_pulses;
        lookup(32'h4000, 300, cyc);
        check("err_cycles", cyc, 86);
        check("err_pulses", err_pulses - e0, 1);
        check("err_acks", ack_n - base, 20);
        check("err_first", ack_log[base + 3], 32'h4006);
        check("err_retry0", ack_log[base + 4], 32'h4000);
        check("err_retry15", ack_log[base + 19], 32'h401E);
        check("err_inst", inst_o, 16'h4000);
        lat = 0;

        // Reset arriving with the 7th ack.
        rst_beat = beat + 7;
        base = ack_n;
        @(negedge clk);
        adr_i = 32'h6000; stb_i = 1'b1;
        #1;
        w = 0;
        while (!rst_i && w < 50) begin
            @(negedge clk);
            #1;
            w++;
        end
        check("rst7_seen", rst_i, 1'b1);
        @(posedge clk);
        #1;
        check("rst7_stb", wb_stb_o, 1'b0);
        @(negedge clk);
        #1;
        check("rst7_nostale", hit_o, 1'b0);
        cyc = 0;
        while (!hit_o && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("rst7_refill_cycles", cyc, 17);
        check("rst7_acks", ack_n - base, 22);
        check("rst7_refill0", ack_log[base + 6], 32'h6000);
        check("rst7_inst", inst_o, 16'h6000);
        check("rst7_data", data_o, 32'h6002_6004);
        lookup(32'h1000, 100, cyc);
        check("rst7_flushed_cycles", cyc, 17);

`ifdef ICACHE_INVALIDATE_EN
        // Flush while idle, then a flush landing in the middle of a fill.
        @(negedge clk);
        stb_i = 1'b0; inval_i = 1'b1;
        @(negedge clk);
        inval_i = 1'b0;
        lookup(32'h1000, 100, cyc);
        check("inval_idle_cycles", cyc, 17);
        base = ack_n;
        @(negedge clk);
        adr_i = 32'h8000; stb_i = 1'b1;
        cyc = 0;
        repeat (5) begin
            @(negedge clk);
            cyc++;
        end
        inval_i = 1'b1;
        @(negedge clk);
        cyc++;
        inval_i = 1'b0;
        while (!hit_o && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("inval_fill_cycles", cyc, 34);
        check("inval_fill_acks", ack_n - base, 32);
        check("inval_fill_inst", inst_o, 16'h8000);
`endif

        check("cyc_eq_stb", cyc_bad, 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
